// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU behind a valid/ready handshake with a shift-add multiplier.
// Define SEQ_ALU_DIV_EN to build the restoring divider for DIVU; otherwise DIVU is illegal.
module seq_alu #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             overflow,
    output logic             err
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MULU = 4'b1000;
`ifdef SEQ_ALU_DIV_EN
    localparam logic [3:0] OP_DIVU = 4'b1001;
`endif

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             zero_q, zero_d;
    logic             overflow_q, overflow_d;
    logic             err_q, err_d;
`ifdef SEQ_ALU_DIV_EN
    logic             div_q, div_d;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
`endif

    logic             start_busy;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   add_full;
    logic             add_ovf;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             alu_err;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

`ifdef SEQ_ALU_DIV_EN
    assign start_busy = (op == OP_MULU) || ((op == OP_DIVU) && (b != '0));
`else
    assign start_busy = (op == OP_MULU);
`endif

    // op[2] is bnegate: SUB/SLT add ~b with carry-in 1
    always_comb begin
        b_eff    = op[2] ? ~b : b;
        add_full = {1'b0, a} + {1'b0, b_eff} + (WIDTH+1)'(op[2]);
        add_ovf  = (a[WIDTH-1] ^ b_eff[WIDTH-1] ^ add_full[WIDTH-1]) ^ add_full[WIDTH];
        alu_res  = '0;
        alu_ovf  = 1'b0;
        alu_err  = 1'b0;
        case (op)
            OP_AND:         alu_res = a & b;
            OP_OR:          alu_res = a | b;
            OP_ADD, OP_SUB: begin
                alu_res = add_full[WIDTH-1:0];
                alu_ovf = add_ovf;
            end
            OP_SLT:         alu_res = WIDTH'(add_full[WIDTH-1] ^ add_ovf);
            OP_NOR:         alu_res = ~(a | b);
            default:        alu_err = 1'b1;
        endcase
    end

    always_comb begin
        mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
        step_hi = mul_sum[WIDTH:1];
        step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
        // Restoring step: remainder in acc_hi, dividend shifts out of acc_lo as quotient bits shift in
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, mcand_q};
        if (div_q) begin
            step_hi = div_ge ? (div_shift[WIDTH-1:0] - mcand_q) : div_shift[WIDTH-1:0];
            step_lo = {acc_lo_q[WIDTH-2:0], div_ge};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            err_q       <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
            div_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            acc_hi_q    <= acc_hi_d;
            acc_lo_q    <= acc_lo_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
            err_q       <= err_d;
`ifdef SEQ_ALU_DIV_EN
            div_q       <= div_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = start_busy ? BUSY : DONE;
            BUSY:    if (cnt_q == CNT_W'(1)) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        acc_hi_d    = acc_hi_q;
        acc_lo_d    = acc_lo_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        overflow_d  = overflow_q;
        err_d       = err_q;
`ifdef SEQ_ALU_DIV_EN
        div_d       = div_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (start_busy) begin
                        cnt_d    = CNT_W'(WIDTH);
                        acc_hi_d = '0;
                        mcand_d  = a;
                        acc_lo_d = b;
`ifdef SEQ_ALU_DIV_EN
                        div_d = (op == OP_DIVU);
                        if (op == OP_DIVU) begin
                            mcand_d  = b;
                            acc_lo_d = a;
                        end
`endif
                    end
`ifdef SEQ_ALU_DIV_EN
                    else if (op == OP_DIVU) begin
                        result_d    = '1;
                        result_hi_d = a;
                        zero_d      = 1'b0;
                        overflow_d  = 1'b0;
                        err_d       = 1'b1;
                    end
`endif
                    else begin
                        result_d    = alu_res;
                        result_hi_d = '0;
                        zero_d      = (alu_res == '0);
                        overflow_d  = alu_ovf;
                        err_d       = alu_err;
                    end
                end
            end
            BUSY: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    result_d    = step_lo;
                    result_hi_d = step_hi;
                    zero_d      = ({step_hi, step_lo} == '0);
                    overflow_d  = 1'b0;
                    err_d       = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign zero      = zero_q;
    assign overflow  = overflow_q;
    assign err       = err_q;

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the combinational 32-bit ALU.
- Keeps the AND/OR/ADD/SUB/SLT/NOR operation set, generalised to WIDTH bits.
- Adds an iterative shift-add multiplier, plus an optional restoring divider.
- Sits between the ID/EX operand registers and writeback, behind a valid/ready handshake, so the core stalls while multi-cycle ops run.

Parameters:
- WIDTH, default 32: operand and result width; legal range 8..64.
- CNT_W, default 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and op are valid this cycle.
- in_ready  out  1  block can accept a new operation.
- op  in  4  {ainvert, bnegate, operation[1:0]}:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
  - 1000 MULU, 1001 DIVU.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result fields are valid.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  low result: ALU result, product low half, or quotient.
- result_hi  out  WIDTH  product high half or remainder; 0 for single-cycle ops.
- zero  out  1  {result_hi, result} == 0.
- overflow  out  1  signed overflow on ADD/SUB; 0 otherwise.
- err  out  1  illegal op or divide-by-zero.

Behaviour:
- Reset (asynchronous, any state, including mid-multiply):
  - State returns to IDLE.
  - in_ready=1 is visible after reset deassertion.
  - out_valid, result, result_hi, zero, overflow, err, counter and internal registers all go to 0.
- States:
  - IDLE: in_ready=1.
  - BUSY: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accept:
  - An op is accepted when in_valid && in_ready.
  - a, b and op are latched on acceptance; later input changes are ignored until the next accept.
- Single-cycle ops (AND, OR, ADD, SUB, SLT, NOR):
  - IDLE -> DONE.
  - out_valid rises on the edge after acceptance (latency 1).
- ADD/SUB:
  - Use WIDTH-bit modular arithmetic.
  - overflow = carry-in of MSB XOR carry-out of MSB.
- SLT:
  - result = {0..0, sign(a-b) XOR overflow(a-b)}, which is correct under signed overflow.
  - overflow output is 0 for SLT.
- MULU (unsigned):
  - IDLE -> BUSY.
  - Each BUSY cycle: if multiplier LSB is 1, add multiplicand to the high accumulator; then shift {acc_hi, acc_lo} right by one.
  - Exactly WIDTH BUSY cycles, then DONE.
  - out_valid asserted WIDTH+1 cycles after acceptance.
  - {result_hi, result} = a*b.
- Handshake:
  - DONE holds every output stable until out_valid && out_ready, then goes to IDLE.
  - No new accept in the same cycle as the DONE->IDLE transition; one bubble cycle minimum.
  - out_ready is ignored outside DONE.
- Illegal op:
  - IDLE -> DONE after 1 cycle with err=1 and result=result_hi=0.
  - zero=1, overflow=0.
  - Covers any encoding not listed, and DIVU when SEQ_ALU_DIV_EN is undefined.
- Counter:
  - CNT_W-bit, loaded with WIDTH on entry to BUSY, decrements each cycle.
  - BUSY -> DONE when the counter reaches 1 and that cycle's step completes.
- err, overflow and zero are registered together with result; all fields update only on entry to DONE.

Optional Feature:
- Macro: SEQ_ALU_DIV_EN.
- Defined (DIVU is a restoring divider, unsigned):
  - IDLE -> BUSY for WIDTH cycles -> DONE; latency WIDTH+1.
  - result = a / b; result_hi = a % b.
  - b == 0: skip BUSY, DONE after 1 cycle with result = all ones, result_hi = a, err=1.
- Undefined:
  - No divider logic is synthesised.
  - op 1001 follows the illegal-op rule.

Test Plan:
- WIDTH=32, ADD a=0x7FFFFFFF b=1 -> 1 cycle later: out_valid=1, result=0x80000000, overflow=1, zero=0, err=0.
- SUB a=5 b=5 -> result=0, zero=1, overflow=0. SLT a=0x80000000 b=1 -> result=1. SLT a=0x7FFFFFFF b=0xFFFFFFFF -> result=0.
- MULU a=0xFFFFFFFF b=0xFFFFFFFF, out_ready held 0 -> out_valid at cycle 33; result_hi=0xFFFFFFFE, result=0x00000001, held stable for 5 cycles; out_ready=1 -> IDLE next edge, in_ready=1 one cycle later.
- Start MULU a=3 b=7, assert rst_n=0 at BUSY cycle 10 -> all outputs 0 immediately. Then ADD a=2 b=3 -> result=5 after 1 cycle, with no stale product.
- op=0011 -> err=1, result=0, zero=1. DIVU a=100 b=7: with SEQ_ALU_DIV_EN, result=14 and result_hi=2 at cycle 33; without it, err=1.
- SEQ_ALU_DIV_EN defined, DIVU a=0x1234 b=0 -> 1 cycle later: result=0xFFFFFFFF, result_hi=0x1234, err=1. Repeat ADD at WIDTH=8: 0x7F+0x01 -> 0x80, overflow=1.
